// File: rtl/mult_share_pkg.sv
// Shared types and default sizing for the shared-multiplier arbiter.
package mult_share_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W_DEF    = 2;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/eight_bit_multiplier.sv
// Combinational 8x8 unsigned multiplier producing the full 16-bit product.
module eight_bit_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = 16'(a) * 16'(b);

endmodule

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W:0] w_pos;

  // Scan from the pointer, claim the first requester found.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_pos >= (ID_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (ID_W+1)'(NUM_REQ);
      end else begin
        w_pos = w_pos;
      end
      if (!o_any && i_req[w_pos[ID_W-1:0]]) begin
        o_any                    = 1'b1;
        o_grant[w_pos[ID_W-1:0]] = 1'b1;
        o_idx                    = w_pos[ID_W-1:0];
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 8x8 multiplier among NUM_REQ requesters,
// with a valid/ready response channel tagged by requester ID.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [7:0]           resp_data,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     txn_count
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [ID_W:0]      w_ptr_inc;
  logic [7:0]         r_op_a;
  logic [7:0]         r_op_b;
  logic [ID_W-1:0]    r_id;
  logic               r_resp_valid;
  logic [ID_W-1:0]    r_resp_id;
  logic [7:0]         r_resp_data;
  logic [CNT_W-1:0]   r_txn_count;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_resp_done;
  logic [15:0]        w_prod;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  eight_bit_multiplier u_mul (
    .a (r_op_a),
    .b (r_op_b),
    .p (w_prod)
  );

  // Next state, pointer advance and handshake qualifiers.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_resp_done = 1'b0;
    w_ptr_inc   = {1'b0, w_idx} + (ID_W+1)'(1);
    if (w_ptr_inc >= (ID_W+1)'(NUM_REQ)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_ptr_inc[ID_W-1:0];
    end
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_MUL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL:  w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (r_resp_valid && resp_ready) begin
          w_resp_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and datapath capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_op_a       <= 8'd0;
      r_op_b       <= 8'd0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= 8'd0;
      r_txn_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a   <= req_a[8*w_idx +: 8];
        r_op_b   <= req_b[8*w_idx +: 8];
        r_id     <= w_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == ST_MUL) begin
        r_resp_data  <= w_prod[7:0];
        r_resp_id    <= r_id;
        r_resp_valid <= 1'b1;
      end else if (w_resp_done) begin
        r_resp_valid <= 1'b0;
        r_txn_count  <= r_txn_count + CNT_W'(1);
      end
    end
  end

  // Grant is only visible in IDLE and never while reset is held.
  assign req_ready  = (w_accept && !rst) ? w_grant : '0;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != ST_IDLE);
  assign txn_count  = r_txn_count;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: directed requests, monitor-side checking.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [7:0]     resp_data;
  logic           resp_ready = 1'b1;
  logic           busy;
  logic [15:0]    txn_count;

  int tests = 0;
  int fails = 0;
  int resp_seen = 0;
  logic [9:0] exp_q[$];

  mult_share_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is matched against the queue head.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && resp_valid && resp_ready) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got id %0d data %0d expected none", resp_id, resp_data);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", 32'(resp_id), 32'(e[9:8]));
        check("resp_data", 32'(resp_data), 32'(e[7:0]));
      end
    end
  end

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  // Raise vmask, expect grant exp_g; optionally push the expected response.
  task automatic do_req(input logic [N-1:0] vmask, input logic [N-1:0] exp_g,
                        input logic [1:0] exp_id, input logic [7:0] exp_d, input bit push);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = vmask;
    if (push) exp_q.push_back({exp_id, exp_d});
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL grant_timeout: got %b expected %b", req_ready, exp_g);
    end else begin
      check("req_ready", 32'(req_ready), 32'(exp_g));
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_txn_count", 32'(txn_count), 0);
    check("rst_req_ready", 32'(req_ready), 0);

    // Single request with latency probe.
    set_ops(2, 8'd12, 8'd13);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    exp_q.push_back({2'd2, 8'd156});
    @(negedge clk);
    check("single_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("lat_mul_valid", 32'(resp_valid), 0);
    check("lat_mul_busy", 32'(busy), 1);
    @(negedge clk);
    check("lat_resp_valid", 32'(resp_valid), 1);
    wait_drain();
    check("txn_after_single", 32'(txn_count), 1);

    // Modulo wrap cases.
    set_ops(0, 8'd200, 8'd3);
    do_req(4'b0001, 4'b0001, 2'd0, 8'd88, 1'b1);
    wait_drain();
    set_ops(3, 8'd255, 8'd255);
    do_req(4'b1000, 4'b1000, 2'd3, 8'd1, 1'b1);
    wait_drain();
    check("txn_after_wrap", 32'(txn_count), 3);

    // Fairness: all requesters persistent, pointer starts at 0.
    set_ops(0, 8'd2, 8'd3);
    set_ops(1, 8'd16, 8'd17);
    set_ops(2, 8'd100, 8'd5);
    set_ops(3, 8'd15, 8'd15);
    exp_q.push_back({2'd0, 8'd6});
    exp_q.push_back({2'd1, 8'd16});
    exp_q.push_back({2'd2, 8'd244});
    exp_q.push_back({2'd3, 8'd225});
    exp_q.push_back({2'd0, 8'd6});
    exp_q.push_back({2'd1, 8'd16});
    resp_seen = 0;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    begin
      int cyc;
      cyc = 0;
      while (resp_seen < 6 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      req_valid = '0;
      check("fair_cycles", 32'(cyc), 18);
    end
    wait_drain();
    check("txn_after_fair", 32'(txn_count), 9);

    // Backpressure: response held while others wait.
    resp_ready = 1'b0;
    set_ops(1, 8'd7, 8'd9);
    do_req(4'b0010, 4'b0010, 2'd1, 8'd63, 1'b1);
    @(negedge clk);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 1);
      check("bp_id", 32'(resp_id), 1);
      check("bp_data", 32'(resp_data), 63);
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_busy", 32'(busy), 1);
    end
    req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(resp_valid), 0);
    check("txn_after_bp", 32'(txn_count), 10);

    // Reset during MUL discards the transaction; pointer returns to 0.
    set_ops(1, 8'd10, 8'd10);
    do_req(4'b0010, 4'b0010, 2'd1, 8'd100, 1'b0);
    #1;
    rst = 1'b1;
    req_valid = 4'($urandom_range(1, 15));
    req_a = $urandom;
    req_b = $urandom;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 0);
    check("mid_rst_id", 32'(resp_id), 0);
    check("mid_rst_data", 32'(resp_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_count", 32'(txn_count), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_resp", 32'(resp_valid), 0);
    end
    set_ops(1, 8'd3, 8'd4);
    set_ops(3, 8'd5, 8'd6);
    do_req(4'b1010, 4'b0010, 2'd1, 8'd12, 1'b1);
    wait_drain();
    do_req(4'b1000, 4'b1000, 2'd3, 8'd30, 1'b1);
    wait_drain();
    check("txn_final", 32'(txn_count), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
